// File: rtl/systolic_setup_left_in_pkg.sv
// Shared definitions for the systolic array left-edge input path.
package systolic_setup_left_in_pkg;

    localparam int DATA_SIZE_DEF = 8;
    localparam int MAC_WIDTH_DEF = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } skew_state_t;

    // Flat position of element A[i][k] within a W x W matrix bus.
    function automatic int elem_idx(input int i, input int k, input int w = MAC_WIDTH_DEF);
        return k * w + i;
    endfunction

    // Width of a counter that must hold 0..2W-2.
    function automatic int step_width(input int w);
        return (2 * w - 1 > 1) ? $clog2(2 * w - 1) : 1;
    endfunction

endpackage

// File: rtl/systolic_setup_left_in_skew_lane.sv
// One row of the diagonal wavefront: presents A[ROW][step-ROW] or zero.
module systolic_skew_lane
    import systolic_setup_left_in_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int MAC_WIDTH = MAC_WIDTH_DEF,
    parameter int ROW       = 0,
    parameter int STEP_W    = step_width(MAC_WIDTH)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           active,
    input  logic [STEP_W-1:0]              step,
    input  logic [DATA_SIZE*MAC_WIDTH-1:0] row_data,
    output logic [DATA_SIZE-1:0]           lane_out
);

    logic [DATA_SIZE-1:0] sel;

    // Pick the column that lines up with this row on the given step; zero pads the skew triangle.
    always_comb begin
        sel = '0;
        for (int k = 0; k < MAC_WIDTH; k++) begin
            if (active && (int'(step) == ROW + k)) begin
                sel = row_data[k*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // Registered lane drive into the array.
    always_ff @(posedge clock) begin
        if (reset) begin
            lane_out <= '0;
        end else begin
            lane_out <= sel;
        end
    end

endmodule

// File: rtl/systolic_setup_left_in.sv
// Left-edge input skewer: captures matrix A on instr and streams it as a diagonal wavefront.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no matrix in flight, lanes drive zero, all slots requesting
//   ST_STREAM | step counter walks 0..2W-2, lanes present the skewed rows
module systolic_setup_left_in
    import systolic_setup_left_in_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int MAC_WIDTH = MAC_WIDTH_DEF
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     instr,
    input  logic [DATA_SIZE*MAC_WIDTH*MAC_WIDTH-1:0] matrix_in,
    output logic [MAC_WIDTH*MAC_WIDTH-1:0]           matrix_in_request,
    output logic [DATA_SIZE*MAC_WIDTH-1:0]           matrix_out
);

    localparam int                STEP_W    = step_width(MAC_WIDTH);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * MAC_WIDTH - 2);

    skew_state_t state_q, state_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_next;
    logic [DATA_SIZE*MAC_WIDTH*MAC_WIDTH-1:0] buffer_q;
    logic [DATA_SIZE*MAC_WIDTH*MAC_WIDTH-1:0] src_matrix;
    logic at_last;
    logic start;
    logic lane_active;

    assign at_last = (state_q == ST_STREAM) && (step_q == LAST_STEP);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a start on the final step keeps streaming with no bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (instr) state_d = ST_STREAM;
            ST_STREAM: if (at_last && !instr) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: capture strobe, lane enable and the step the lanes will show next.
    always_comb begin
        start       = instr && ((state_q == ST_IDLE) || at_last);
        lane_active = start || ((state_q == ST_STREAM) && !at_last);
        step_next   = start ? '0 : step_q + STEP_W'(1);
    end

    // Step counter; parks at zero while idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            step_q <= '0;
        end else if (start) begin
            step_q <= '0;
        end else if (state_q == ST_STREAM) begin
            step_q <= at_last ? '0 : step_q + STEP_W'(1);
        end
    end

    // Operand buffer, written only on a start so a mid-stream instr cannot disturb it.
    always_ff @(posedge clock) begin
        if (reset) begin
            buffer_q <= '0;
        end else if (start) begin
            buffer_q <= matrix_in;
        end
    end

    // Step 0 is registered on the capture edge itself, before the buffer holds the data.
    assign src_matrix = start ? matrix_in : buffer_q;

    // Slot A[i][k] frees up once the step that presented it (t = i+k) has ended.
    always_ff @(posedge clock) begin
        if (reset) begin
            matrix_in_request <= '1;
        end else if (start) begin
            matrix_in_request <= '0;
        end else if (state_q == ST_STREAM) begin
            for (int i = 0; i < MAC_WIDTH; i++) begin
                for (int k = 0; k < MAC_WIDTH; k++) begin
                    if (int'(step_q) == i + k) begin
                        matrix_in_request[elem_idx(i, k, MAC_WIDTH)] <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < MAC_WIDTH; gi++) begin : g_row
        logic [DATA_SIZE*MAC_WIDTH-1:0] row_data;

        for (genvar gk = 0; gk < MAC_WIDTH; gk++) begin : g_col
            assign row_data[gk*DATA_SIZE +: DATA_SIZE] =
                src_matrix[elem_idx(gi, gk, MAC_WIDTH)*DATA_SIZE +: DATA_SIZE];
        end

        systolic_skew_lane #(
            .DATA_SIZE (DATA_SIZE),
            .MAC_WIDTH (MAC_WIDTH),
            .ROW       (gi),
            .STEP_W    (STEP_W)
        ) u_lane (
            .clock    (clock),
            .reset    (reset),
            .active   (lane_active),
            .step     (step_next),
            .row_data (row_data),
            .lane_out (matrix_out[gi*DATA_SIZE +: DATA_SIZE])
        );
    end

endmodule

// File: tb/tb_systolic_setup_left_in.sv
// Directed bench for the left-edge skewer with W=4, D=8, A[i][k]=16*i+k+1.
module tb_systolic_setup_left_in;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         instr = 1'b0;
    logic [127:0] matrix_in = '0;
    logic [15:0]  matrix_in_request;
    logic [31:0]  matrix_out;

    logic [127:0] mat_a, mat_b;
    logic [31:0]  exp_a [7];
    int total = 0;
    int bad   = 0;

    systolic_setup_left_in #(.DATA_SIZE(8), .MAC_WIDTH(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .instr             (instr),
        .matrix_in         (matrix_in),
        .matrix_in_request (matrix_in_request),
        .matrix_out        (matrix_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Lanes of B = A + 100 on every element; padded lanes stay zero.
    function automatic logic [31:0] plus100(input logic [31:0] v);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = (v[b*8 +: 8] == 8'd0) ? 8'd0 : v[b*8 +: 8] + 8'd100;
        end
        return r;
    endfunction

    // Request bits expected while showing step t: every slot with i+k < t is free.
    function automatic logic [15:0] req_at(input int t);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (i + k < t) r[k*4+i] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic start_matrix(input logic [127:0] m);
        matrix_in = m;
        instr = 1'b1;
        tick();
        instr = 1'b0;
        matrix_in = {4{32'hDEADBEEF}};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (matrix_out !== 32'h0) begin
            bad++; $display("FAIL reset_out got=%h want=%h", matrix_out, 32'h0);
        end
        total++;
        if (matrix_in_request !== 16'hFFFF) begin
            bad++; $display("FAIL reset_req got=%h want=%h", matrix_in_request, 16'hFFFF);
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (matrix_out !== 32'h0 || matrix_in_request !== 16'hFFFF) begin
                bad++; $display("FAIL idle_quiet c=%0d got=%h/%h want=0/ffff", c, matrix_out, matrix_in_request);
            end
        end
    endtask

    task automatic test_stream();
        start_matrix(mat_a);
        for (int t = 0; t < 7; t++) begin
            if (t > 0) tick();
            total++;
            if (matrix_out !== exp_a[t]) begin
                bad++; $display("FAIL stream_lanes t=%0d got=%h want=%h", t, matrix_out, exp_a[t]);
            end
            total++;
            if (matrix_in_request !== req_at(t)) begin
                bad++; $display("FAIL stream_req t=%0d got=%h want=%h", t, matrix_in_request, req_at(t));
            end
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (matrix_out !== 32'h0 || matrix_in_request !== 16'hFFFF) begin
                bad++; $display("FAIL stream_end c=%0d got=%h/%h want=0/ffff", c, matrix_out, matrix_in_request);
            end
        end
    endtask

    task automatic test_ignored_instr();
        start_matrix(mat_a);
        for (int t = 0; t < 7; t++) begin
            if (t > 0) tick();
            total++;
            if (matrix_out !== exp_a[t] || matrix_in_request !== req_at(t)) begin
                bad++; $display("FAIL ignore_instr t=%0d got=%h/%h want=%h/%h",
                                t, matrix_out, matrix_in_request, exp_a[t], req_at(t));
            end
            if (t == 2) begin
                matrix_in = mat_b;
                instr = 1'b1;
            end else begin
                instr = 1'b0;
            end
        end
        instr = 1'b0;
        tick();
        total++;
        if (matrix_out !== 32'h0) begin
            bad++; $display("FAIL ignore_end got=%h want=%h", matrix_out, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        start_matrix(mat_a);
        for (int t = 1; t < 7; t++) tick();
        total++;
        if (matrix_out !== exp_a[6]) begin
            bad++; $display("FAIL b2b_last_a got=%h want=%h", matrix_out, exp_a[6]);
        end
        start_matrix(mat_b);
        total++;
        if (matrix_out !== 32'h0000_0065) begin
            bad++; $display("FAIL b2b_first_b got=%h want=%h", matrix_out, 32'h0000_0065);
        end
        total++;
        if (matrix_in_request !== 16'h0000) begin
            bad++; $display("FAIL b2b_req_clear got=%h want=%h", matrix_in_request, 16'h0000);
        end
        for (int t = 1; t < 7; t++) begin
            tick();
            total++;
            if (matrix_out !== plus100(exp_a[t])) begin
                bad++; $display("FAIL b2b_lanes t=%0d got=%h want=%h", t, matrix_out, plus100(exp_a[t]));
            end
        end
        tick();
        total++;
        if (matrix_out !== 32'h0 || matrix_in_request !== 16'hFFFF) begin
            bad++; $display("FAIL b2b_end got=%h/%h want=0/ffff", matrix_out, matrix_in_request);
        end
    endtask

    task automatic test_reset_abort();
        start_matrix(mat_a);
        for (int t = 1; t < 4; t++) tick();
        total++;
        if (matrix_out !== exp_a[3]) begin
            bad++; $display("FAIL abort_pre got=%h want=%h", matrix_out, exp_a[3]);
        end
        reset = 1'b1;
        instr = 1'b1;
        matrix_in = mat_b;
        tick();
        total++;
        if (matrix_out !== 32'h0 || matrix_in_request !== 16'hFFFF) begin
            bad++; $display("FAIL abort_reset got=%h/%h want=0/ffff", matrix_out, matrix_in_request);
        end
        reset = 1'b0;
        instr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (matrix_out !== 32'h0 || matrix_in_request !== 16'hFFFF) begin
                bad++; $display("FAIL abort_idle c=%0d got=%h/%h want=0/ffff", c, matrix_out, matrix_in_request);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                mat_a[(k*4+i)*8 +: 8] = 8'(16*i + k + 1);
                mat_b[(k*4+i)*8 +: 8] = 8'(16*i + k + 101);
            end
        end
        exp_a[0] = 32'h00_00_00_01;
        exp_a[1] = 32'h00_00_11_02;
        exp_a[2] = 32'h00_21_12_03;
        exp_a[3] = 32'h31_22_13_04;
        exp_a[4] = 32'h32_23_14_00;
        exp_a[5] = 32'h33_24_00_00;
        exp_a[6] = 32'h34_00_00_00;

        test_reset();
        test_stream();
        test_ignored_instr();
        test_back_to_back();
        test_reset_abort();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
